// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the instruction memory.
// Frame: count_hi, count_lo, N x 4 data bytes (MSB first), checksum byte.
// The processor stays stalled until a checksum-verified load completes.
module imem_loader #(
  parameter int unsigned size    = 32,
  parameter int unsigned MemSize = 512
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            imem_wea,
  output logic [size-1:0] imem_addra,
  output logic [size-1:0] imem_dina,
  output logic            cpu_run,
  output logic            load_err,
  output logic            busy
);

  localparam int unsigned CntW  = 16;
  localparam int unsigned SumW  = 8;
  localparam int unsigned WordW = 32;

  localparam logic [2:0] ST_CNT_HI = 3'd0;
  localparam logic [2:0] ST_CNT_LO = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [CntW-1:0] count;
  logic [CntW-1:0] word_idx;
  logic [CntW-1:0] word_idx_inc;
  logic [CntW-1:0] count_full;
  logic [SumW-1:0] sum;
  logic [1:0]      byte_idx;
  logic [WordW-1:0] word_asm;
  logic            accept;

  // Handshake and state decodes; everything here derives from registers
  assign rx_ready = (state == ST_CNT_HI) || (state == ST_CNT_LO) ||
                    (state == ST_DATA)   || (state == ST_CSUM);
  assign accept   = rx_valid & rx_ready;
  assign imem_wea = (state == ST_WRITE);
  assign cpu_run  = (state == ST_RUN);
  assign load_err = (state == ST_ERR);
  assign busy     = (state == ST_CNT_LO) || (state == ST_DATA) ||
                    (state == ST_WRITE)  || (state == ST_CSUM);

  assign imem_addra   = size'(word_idx);
  assign imem_dina    = size'(word_asm);
  assign word_idx_inc = word_idx + CntW'(1);
  assign count_full   = {count[15:8], rx_data};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_CNT_HI;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CNT_HI: if (accept) state_nxt = ST_CNT_LO;
      ST_CNT_LO: begin
        if (accept) begin
          if (32'(count_full) > 32'(MemSize)) state_nxt = ST_ERR;
          else if (count_full == '0)          state_nxt = ST_CSUM;
          else                                state_nxt = ST_DATA;
        end
      end
      ST_DATA:   if (accept && (byte_idx == 2'd3)) state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = (word_idx_inc == count) ? ST_CSUM : ST_DATA;
      ST_CSUM: begin
        if (accept) state_nxt = (rx_data == sum) ? ST_RUN : ST_ERR;
      end
      ST_RUN:    state_nxt = ST_RUN;
      ST_ERR:    state_nxt = ST_ERR;
      default:   state_nxt = ST_CNT_HI;
    endcase
  end

  // Count, checksum, word assembly and index registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      sum      <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      word_asm <= '0;
    end else begin
      if (accept && (state == ST_CNT_HI)) begin
        count[15:8] <= rx_data;
        sum         <= rx_data;
      end
      if (accept && (state == ST_CNT_LO)) begin
        count[7:0] <= rx_data;
        sum        <= sum + rx_data;
      end
      if (accept && (state == ST_DATA)) begin
        word_asm <= {word_asm[WordW-9:0], rx_data};
        sum      <= sum + rx_data;
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == ST_WRITE) word_idx <= word_idx_inc;
    end
  end

endmodule
